// File: rtl/memory_access.sv
// memory_access: memory-access pipeline stage issuing single-beat req/ack data-memory
// requests and registering the write-back / forwarding value. Optional macro: MEM_TIMEOUT_EN.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module   : memory_access                                                 |
// | Function : load/store issue over req/ack, upstream stall, write-back reg |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module memory_access #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic [31:0]       aluResIn,
  input  logic [31:0]       storeDataIn,
  input  logic [4:0]        rdIn,
  input  logic              regWrIn,
  input  logic              m2RegIn,
  input  logic              loadIn,
  input  logic              storeIn,
  input  logic              dmemAck,
  input  logic [31:0]       dmemRData,
  output logic              dmemReq,
  output logic              dmemWe,
  output logic [ADDR_W-1:0] dmemAddr,
  output logic [31:0]       dmemWData,
  output logic              stallOut,
  output logic [31:0]       M_W_data,
  output logic [4:0]        rdOut,
  output logic              regWrOut,
  output logic              memErr
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_REQ  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       res_q, res_d;
  logic              we_q, we_d;
  logic              m2reg_q, m2reg_d;
  logic              regwr_lat_q, regwr_lat_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_we_q, wb_we_d;
  logic              w_mem_op;
  logic              w_timeout;

  assign w_mem_op = loadIn | storeIn;

`ifdef MEM_TIMEOUT_EN
  localparam int c_CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               mem_err_q, mem_err_d;

  // cnt_q counts REQ cycles already spent waiting; the abort fires in the
  // REQ cycle that would bring the count to TIMEOUT.
  assign w_timeout = (state_q == c_REQ) && !dmemAck &&
                     ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT));
  assign cnt_d     = (state_q == c_REQ) ? cnt_q + c_CNT_W'(1) : '0;
  assign mem_err_d = mem_err_q | w_timeout;

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign memErr = mem_err_q;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
  assign memErr           = 1'b0;
`endif

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) state_q <= c_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_mem_op)              state_d = c_REQ;
      c_REQ:   if (dmemAck || w_timeout)  state_d = c_IDLE;
      default:                            state_d = c_IDLE;
    endcase
  end

  always_comb begin
    stallOut    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    res_d       = res_q;
    we_d        = we_q;
    m2reg_d     = m2reg_q;
    regwr_lat_d = regwr_lat_q;
    rd_lat_d    = rd_lat_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_we_d     = 1'b0;
    case (state_q)
      c_IDLE: begin
        stallOut = w_mem_op;
        if (w_mem_op) begin
          addr_d      = aluResIn[ADDR_W-1:0];
          wdata_d     = storeDataIn;
          res_d       = aluResIn;
          we_d        = storeIn;
          m2reg_d     = m2RegIn;
          regwr_lat_d = regWrIn;
          rd_lat_d    = rdIn;
        end else begin
          wb_data_d = aluResIn;
          wb_rd_d   = rdIn;
          wb_we_d   = regWrIn;
        end
      end
      c_REQ: begin
        stallOut = !(dmemAck || w_timeout);
        if (dmemAck) begin
          wb_data_d = m2reg_q ? dmemRData : res_q;
          wb_rd_d   = rd_lat_q;
          wb_we_d   = regwr_lat_q & ~we_q;
        end else if (w_timeout) begin
          wb_data_d = '0;
          wb_rd_d   = rd_lat_q;
          wb_we_d   = regwr_lat_q & ~we_q;
        end
      end
      default: ;
    endcase
    // Gate the only combinational output so reset forces every output low.
    stallOut = stallOut & aclr;
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      res_q       <= '0;
      we_q        <= 1'b0;
      m2reg_q     <= 1'b0;
      regwr_lat_q <= 1'b0;
      rd_lat_q    <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      res_q       <= res_d;
      we_q        <= we_d;
      m2reg_q     <= m2reg_d;
      regwr_lat_q <= regwr_lat_d;
      rd_lat_q    <= rd_lat_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
    end
  end

  assign dmemReq   = (state_q == c_REQ);
  assign dmemWe    = we_q;
  assign dmemAddr  = addr_q;
  assign dmemWData = wdata_q;
  assign M_W_data  = wb_data_q;
  assign rdOut     = wb_rd_q;
  assign regWrOut  = wb_we_q;

endmodule

`default_nettype wire
